// File: rtl/rv_mc_ctrl_if.sv
// Control/handshake bundle between the multi-cycle controller (master) and
// the instruction/data memories plus datapath (slave).
interface rv_mc_ctrl_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int CONTROLL_WIDTH = 4
) ();
  logic [DATA_WIDTH-1:0]     instr;
  logic                      instr_valid;
  logic                      instr_ready;
  logic                      ir_we;
  logic                      zero;
  logic [CONTROLL_WIDTH-1:0] alu_ctrl;
  logic                      alu_src_b;
  logic                      reg_we;
  logic [1:0]                result_src;
  logic                      mem_re;
  logic                      mem_we;
  logic                      mem_ack;
  logic                      pc_we;
  logic                      pc_src;
  logic                      illegal;

  modport master (
    input  instr, instr_valid, zero, mem_ack,
    output instr_ready, ir_we, alu_ctrl, alu_src_b, reg_we, result_src,
           mem_re, mem_we, pc_we, pc_src, illegal
  );

  modport slave (
    output instr, instr_valid, zero, mem_ack,
    input  instr_ready, ir_we, alu_ctrl, alu_src_b, reg_we, result_src,
           mem_re, mem_we, pc_we, pc_src, illegal
  );
endinterface

// File: rtl/rv_mc_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing.
// Optional retired-instruction counter enabled by RV_MC_CTRL_RETIRE_CNT_EN.
module rv_mc_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int CONTROLL_WIDTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  rv_mc_ctrl_if.master bus
`ifdef RV_MC_CTRL_RETIRE_CNT_EN
  ,
  output logic [31:0]  retire_cnt
`endif
);

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB, BRANCH, JUMP, TRAP
  } state_t;

  localparam logic [CONTROLL_WIDTH-1:0] ALU_ADD = CONTROLL_WIDTH'(0);
  localparam logic [CONTROLL_WIDTH-1:0] ALU_SUB = CONTROLL_WIDTH'(1);
  localparam logic [CONTROLL_WIDTH-1:0] ALU_AND = CONTROLL_WIDTH'(2);
  localparam logic [CONTROLL_WIDTH-1:0] ALU_OR  = CONTROLL_WIDTH'(3);
  localparam logic [CONTROLL_WIDTH-1:0] ALU_SLT = CONTROLL_WIDTH'(5);
  localparam logic [CONTROLL_WIDTH-1:0] ALU_JAL = CONTROLL_WIDTH'(8);

  state_t                    state_q, state_d;
  logic [DATA_WIDTH-1:0]     ir_q;
  logic                      ready_q, src_b_q, reg_we_q, mem_re_q, mem_we_q;
  logic                      pc_we_q, pc_src_q, br_q, inv_q, illegal_q;
  logic [1:0]                result_src_q;
  logic [CONTROLL_WIDTH-1:0] alu_q;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic       is_load, accept, unused_ir;

  assign opc       = ir_q[6:0];
  assign f3        = ir_q[14:12];
  assign f7        = ir_q[31:25];
  assign is_load   = (opc == 7'b0000011);
  assign accept    = ready_q & bus.instr_valid;
  assign unused_ir = ^ir_q[24:7];

  function automatic state_t decode_next(input logic [6:0] op, input logic [2:0] fn3,
                                         input logic [6:0] fn7);
    state_t nxt;
    nxt = TRAP;
    case (op)
      7'b0110011:
        if ((fn7 == 7'h00 && (fn3 == 3'b000 || fn3 == 3'b111 || fn3 == 3'b110 ||
                              fn3 == 3'b010)) || (fn7 == 7'h20 && fn3 == 3'b000))
          nxt = EXEC_R;
      7'b0010011:             if (fn3 == 3'b000) nxt = EXEC_I;
      7'b0000011, 7'b0100011: nxt = MEM_ADDR;
      7'b1100011:             if (fn3[2:1] != 2'b01) nxt = BRANCH;
      7'b1101111:             nxt = JUMP;
      default:                nxt = TRAP;
    endcase
    return nxt;
  endfunction

  function automatic logic [CONTROLL_WIDTH-1:0] r_op(input logic [2:0] fn3, input logic [6:0] fn7);
    if (fn7[5]) return ALU_SUB;
    case (fn3)
      3'b111:  return ALU_AND;
      3'b110:  return ALU_OR;
      3'b010:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // Branch compare selection; bne reuses ADD with the zero flag inverted.
  function automatic logic [CONTROLL_WIDTH-1:0] br_op(input logic [2:0] fn3);
    case (fn3)
      3'b100:  return ALU_OR;
      3'b101:  return ALU_SUB;
      3'b110:  return ALU_SLT;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:            if (accept) state_d = DECODE;
      DECODE:           state_d = decode_next(opc, f3, f7);
      EXEC_R, EXEC_I:   state_d = WB;
      MEM_ADDR:         state_d = is_load ? MEM_RD : MEM_WR;
      MEM_RD:           if (bus.mem_ack) state_d = WB;
      MEM_WR:           if (bus.mem_ack) state_d = FETCH;
      WB, BRANCH, JUMP: state_d = FETCH;
      TRAP:             state_d = TRAP;
      default:          state_d = TRAP;
    endcase
  end

  // Moore outputs are registered from the upcoming state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      ir_q         <= '0;
      ready_q      <= 1'b0;
      src_b_q      <= 1'b0;
      reg_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      pc_we_q      <= 1'b0;
      pc_src_q     <= 1'b0;
      br_q         <= 1'b0;
      inv_q        <= 1'b0;
      illegal_q    <= 1'b0;
      result_src_q <= 2'd0;
      alu_q        <= ALU_ADD;
    end else begin
      state_q      <= state_d;
      if (accept) ir_q <= bus.instr;
      ready_q      <= 1'b0;
      src_b_q      <= 1'b0;
      reg_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      pc_we_q      <= 1'b0;
      pc_src_q     <= 1'b0;
      br_q         <= 1'b0;
      inv_q        <= 1'b0;
      illegal_q    <= 1'b0;
      result_src_q <= 2'd0;
      alu_q        <= ALU_ADD;
      case (state_d)
        FETCH:    ready_q <= 1'b1;
        EXEC_R:   alu_q   <= r_op(f3, f7);
        EXEC_I:   src_b_q <= 1'b1;
        MEM_ADDR: src_b_q <= 1'b1;
        MEM_RD:   mem_re_q <= 1'b1;
        MEM_WR:   mem_we_q <= 1'b1;
        WB: begin
          reg_we_q     <= 1'b1;
          pc_we_q      <= 1'b1;
          result_src_q <= is_load ? 2'd1 : 2'd0;
        end
        BRANCH: begin
          alu_q   <= br_op(f3);
          pc_we_q <= 1'b1;
          br_q    <= 1'b1;
          inv_q   <= (f3 == 3'b001);
        end
        JUMP: begin
          alu_q        <= ALU_JAL;
          src_b_q      <= 1'b1;
          reg_we_q     <= 1'b1;
          result_src_q <= 2'd2;
          pc_we_q      <= 1'b1;
          pc_src_q     <= 1'b1;
        end
        TRAP:     illegal_q <= 1'b1;
        default:  ;
      endcase
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.ir_we       = accept;
  assign bus.alu_ctrl    = alu_q;
  assign bus.alu_src_b   = src_b_q;
  assign bus.reg_we      = reg_we_q;
  assign bus.result_src  = result_src_q;
  assign bus.mem_re      = mem_re_q;
  assign bus.mem_we      = mem_we_q;
  // A store retires on its ack cycle; a branch resolves from the live zero flag.
  assign bus.pc_we       = pc_we_q | (mem_we_q & bus.mem_ack);
  assign bus.pc_src      = br_q ? (bus.zero ^ inv_q) : pc_src_q;
  assign bus.illegal     = illegal_q;

`ifdef RV_MC_CTRL_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          retire_cnt <= 32'd0;
    else if (bus.pc_we)  retire_cnt <= retire_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Self-checking bench for rv_mc_ctrl: directed instructions, then random ones
// checked against an instruction-level reference model.
module tb_rv_mc_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  rv_mc_ctrl_if bus ();
`ifdef RV_MC_CTRL_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  rv_mc_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef RV_MC_CTRL_RETIRE_CNT_EN
    ,
    .retire_cnt(retire_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;
  int exp_retire = 0;

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5, K_ILL = 6;

  // funct3-indexed op tables; -1 marks encodings that must trap
  int r_op_t[8]  = '{0, -1, 5, -1, -1, -1, 3, 2};
  int br_op_t[8] = '{0, 0, -1, -1, 3, 1, 5, 2};

  function automatic int kind_of(input logic [31:0] w);
    logic [2:0] f3;
    f3 = w[14:12];
    case (w[6:0])
      7'b0110011: begin
        if (w[31:25] == 7'h00 && r_op_t[f3] >= 0) return K_R;
        if (w[31:25] == 7'h20 && f3 == 3'b000) return K_R;
        return K_ILL;
      end
      7'b0010011: return (f3 == 3'b000) ? K_I : K_ILL;
      7'b0000011: return K_LD;
      7'b0100011: return K_ST;
      7'b1100011: return (br_op_t[f3] >= 0) ? K_BR : K_ILL;
      7'b1101111: return K_JAL;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic int op_of(input logic [31:0] w);
    logic [2:0] f3;
    f3 = w[14:12];
    case (kind_of(w))
      K_R:     return (w[31:25] == 7'h20) ? 1 : r_op_t[f3];
      K_BR:    return br_op_t[f3];
      K_JAL:   return 8;
      default: return 0;
    endcase
  endfunction

  function automatic logic [14:0] obs_vec();
    return {bus.instr_ready, bus.ir_we, bus.alu_ctrl, bus.alu_src_b, bus.reg_we,
            bus.result_src, bus.mem_re, bus.mem_we, bus.pc_we, bus.pc_src, bus.illegal};
  endfunction

  function automatic logic [14:0] ev(input logic rdy, input logic irwe, input int alu,
                                     input logic sb, input logic rw, input int rs,
                                     input logic mre, input logic mwe, input logic pw,
                                     input logic ps, input logic ill);
    return {rdy, irwe, 4'(alu), sb, rw, 2'(rs), mre, mwe, pw, ps, ill};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_async"}, obs_vec(), 32'h0);
    bus.instr_valid = 1'b0;
    bus.mem_ack     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_hold"}, obs_vec(), 32'h0);
    rst_n = 1'b1;
    cyc();
    chk({tag, "_fetch"}, obs_vec(), ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_retire = 0;
`ifdef RV_MC_CTRL_RETIRE_CNT_EN
    chk({tag, "_retire"}, retire_cnt, 32'd0);
`endif
  endtask

  // Entered and left just after a rising edge with the controller in FETCH.
  task automatic run(input logic [31:0] w, input int wait_n, input logic z);
    int   kind, op;
    logic take;
    kind = kind_of(w);
    op   = op_of(w);
    take = z ^ (w[14:12] == 3'b001);
    bus.instr = w; bus.instr_valid = 1'b1; bus.zero = z; bus.mem_ack = 1'b0;
    @(negedge clk); chk("accept", obs_vec(), ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc();
    bus.instr_valid = 1'($urandom); bus.mem_ack = 1'($urandom); bus.instr = $urandom;
    @(negedge clk); chk("decode", obs_vec(), ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc();
    bus.mem_ack = 1'($urandom);
    case (kind)
      K_ILL: begin
        for (int i = 0; i < 3; i++) begin
          bus.instr_valid = 1'b1;
          @(negedge clk); chk("trap", obs_vec(), ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
          cyc();
        end
        return;
      end
      K_R, K_I: begin
        @(negedge clk); chk("exec", obs_vec(), ev(0, 0, op, kind == K_I, 0, 0, 0, 0, 0, 0, 0));
        cyc();
        bus.mem_ack = 1'($urandom);
        @(negedge clk); chk("wb", obs_vec(), ev(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
        cyc();
      end
      K_BR: begin
        @(negedge clk); chk("branch", obs_vec(), ev(0, 0, op, 0, 0, 0, 0, 0, 1, take, 0));
        cyc();
      end
      K_JAL: begin
        @(negedge clk); chk("jump", obs_vec(), ev(0, 0, 8, 1, 1, 2, 0, 0, 1, 1, 0));
        cyc();
      end
      default: begin
        @(negedge clk); chk("maddr", obs_vec(), ev(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        cyc();
        for (int k = 0; k <= wait_n; k++) begin
          bus.mem_ack = (k == wait_n);
          @(negedge clk);
          if (kind == K_LD)
            chk("mem_rd", obs_vec(), ev(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
          else
            chk("mem_wr", obs_vec(), ev(0, 0, 0, 0, 0, 0, 0, 1, k == wait_n, 0, 0));
          cyc();
        end
        if (kind == K_LD) begin
          bus.mem_ack = 1'($urandom);
          @(negedge clk); chk("wb_ld", obs_vec(), ev(0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0));
          cyc();
        end
      end
    endcase
    bus.instr_valid = 1'b0;
    bus.mem_ack     = 1'b0;
    exp_retire++;
`ifdef RV_MC_CTRL_RETIRE_CNT_EN
    chk("retire", retire_cnt, 32'(exp_retire));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    bus.instr = '0; bus.instr_valid = 1'b0; bus.zero = 1'b0; bus.mem_ack = 1'b0;
    #2;
    do_reset("rst0");

    // FETCH idles without instr_valid and ignores a stray mem_ack
    bus.mem_ack = 1'b1;
    @(negedge clk); chk("idle", obs_vec(), ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc();
    bus.mem_ack = 1'b0;

    run(32'h002081B3, 0, 1'b0);
    run(32'h402081B3, 0, 1'b0);
    run(32'h00208063, 0, 1'b1);
    run(32'h00208063, 0, 1'b0);
    run(32'h0020C063, 0, 1'b1);
    run(32'h0000A283, 3, 1'b0);
    run(32'h0000006F, 0, 1'b0);
    run(32'h00508093, 0, 1'b0);

    do_reset("rst1");
    run(32'h002081B3, 0, 1'b0);
    run(32'h00208063, 0, 1'b1);
    run(32'h0020A023, 2, 1'b0);
`ifdef RV_MC_CTRL_RETIRE_CNT_EN
    chk("retire3", retire_cnt, 32'd3);
`endif

    run(32'h00000000, 0, 1'b0);
    do_reset("rst_trap");

    // reset lands while a store stalls and mem_ack arrives in the same instant
    bus.instr = 32'h0020A023; bus.instr_valid = 1'b1; bus.mem_ack = 1'b0;
    @(negedge clk); chk("sw_accept", obs_vec(), ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(); bus.instr_valid = 1'b0;
    cyc();
    cyc();
    @(negedge clk); chk("sw_stall", obs_vec(), ev(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    cyc();
    chk("sw_stall2", bus.mem_we, 32'd1);
    bus.mem_ack = 1'b1;
    do_reset("rst_wr");

    for (int n = 0; n < 80; n++) begin
      w = $urandom;
      case ($urandom_range(0, 7))
        0: begin
          w[6:0] = 7'b0110011;
          if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        end
        1: w[6:0] = 7'b0010011;
        2: w[6:0] = 7'b0000011;
        3: w[6:0] = 7'b0100011;
        4: w[6:0] = 7'b1100011;
        5: w[6:0] = 7'b1101111;
        6: begin w[6:0] = 7'b0010011; w[14:12] = 3'b000; end
        default: ;
      endcase
      run(w, $urandom_range(0, 4), 1'($urandom));
      if (kind_of(w) == K_ILL) do_reset("rst_rand");
    end

    @(negedge clk); chk("final_fetch", obs_vec(), ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
